// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines,
// deframes 11-bit frames and decodes make/break/extended key codes.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2clk,
  input  logic       data,
  output logic [7:0] keycode,
  output logic       newkeyStrobe,
  output logic       ext_o,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } state_t;

  logic           clk_s1, clk_s2;
  logic           dat_s1, dat_s2;
  logic           flt_q;
  logic [FCW-1:0] fcnt_q;
  logic           differ;
  logic           flip;
  logic           fall;

  state_t         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           done_q, done_d;
  logic           ok_q, ok_d;
  logic           timeout;

  logic           brk_pend;
  logic           ext_pend;

  // two-stage synchronizers for both PS/2 lines; idle level is high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      dat_s1 <= data;
      dat_s2 <= dat_s1;
    end
  end

  assign differ = (clk_s2 != flt_q);
  assign flip   = differ && (fcnt_q == FC_LAST);
  assign fall   = flip && flt_q;

  // glitch filter: level flips after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flt_q  <= 1'b1;
      fcnt_q <= '0;
    end else if (!differ) begin
      fcnt_q <= '0;
    end else if (flip) begin
      flt_q  <= ~flt_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

  assign timeout = (state_q != IDLE) && (wd_q == WD_MAX);

  // frame FSM state and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  // next-state: one step per filtered falling edge; watchdog abort wins
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    if (state_q == IDLE || flip) begin
      wd_d = '0;
    end else if (!timeout) begin
      wd_d = wd_q + WDW'(1);
    end else begin
      wd_d = wd_q;
    end
    if (timeout) begin
      state_d = IDLE;
      bit_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2) begin
            state_d = SHIFT;
            bit_d   = '0;
          end
        end
        SHIFT: begin
          sh_d  = {dat_s2, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          done_d  = 1'b1;
          ok_d    = (^{sh_q, par_q}) & dat_s2;
          state_d = IDLE;
          bit_d   = '0;
        end
      endcase
    end
  end

  // byte decoder: prefixes, break suppression, error reporting
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      keycode      <= 8'h00;
      newkeyStrobe <= 1'b0;
      ext_o        <= 1'b0;
      frame_err    <= 1'b0;
      brk_pend     <= 1'b0;
      ext_pend     <= 1'b0;
    end else begin
      newkeyStrobe <= 1'b0;
      frame_err    <= 1'b0;
      if (done_q) begin
        if (!ok_q) begin
          frame_err <= 1'b1;
          brk_pend  <= 1'b0;
          ext_pend  <= 1'b0;
        end else if (sh_q == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (sh_q == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (brk_pend) begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end else begin
          keycode      <= sh_q;
          ext_o        <= ext_pend;
          newkeyStrobe <= 1'b1;
          ext_pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: table of frames plus
// hand-written timeout, glitch and reset sequences.
module tb_ps2_keycode_rx;

  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 12;

  logic       CLK;
  logic       RST;
  logic       ps2clk;
  logic       data;
  logic [7:0] keycode;
  logic       newkeyStrobe;
  logic       ext_o;
  logic       frame_err;

  int checks;
  int errors;
  int cyc;
  int fall_cyc;
  int n_strobe;
  int n_ferr;
  int n_both;
  int last_ev;

  ps2_keycode_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ps2clk      (ps2clk),
    .data        (data),
    .keycode     (keycode),
    .newkeyStrobe(newkeyStrobe),
    .ext_o       (ext_o),
    .frame_err   (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    n_strobe = 0;
    n_ferr   = 0;
    n_both   = 0;
    last_ev  = 0;
  end

  always @(negedge CLK) begin
    if (newkeyStrobe) begin
      n_strobe = n_strobe + 1;
      last_ev  = cyc;
    end
    if (frame_err) begin
      n_ferr  = n_ferr + 1;
      last_ev = cyc;
    end
    if (newkeyStrobe && frame_err) n_both = n_both + 1;
  end

  typedef struct {
    logic [7:0] b;
    bit         pflip;
    bit         stopb;
    logic [7:0] key;
    bit         ext;
    int         ns;
    int         ne;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    data = b;
    wait_cyc(HALF);
    ps2clk   = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip,
                            input bit stopb);
    logic [10:0] f;
    f = {stopb, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    data = 1'b1;
    wait_cyc(FL + 6);
  endtask

  task automatic chk_outs_reset(input string tag);
    chk({tag, "_key"}, int'(keycode), 0);
    chk({tag, "_stb"}, int'(newkeyStrobe), 0);
    chk({tag, "_ext"}, int'(ext_o), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
  endtask

  initial begin
    int s0;
    int e0;
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    ps2clk = 1'b1;
    data   = 1'b1;

    vt[0]  = '{8'h1D, 0, 1, 8'h1D, 0, 1, 0};
    vt[1]  = '{8'hF0, 0, 1, 8'h1D, 0, 0, 0};
    vt[2]  = '{8'h1D, 0, 1, 8'h1D, 0, 0, 0};
    vt[3]  = '{8'h1B, 0, 1, 8'h1B, 0, 1, 0};
    vt[4]  = '{8'hE0, 0, 1, 8'h1B, 0, 0, 0};
    vt[5]  = '{8'h75, 0, 1, 8'h75, 1, 1, 0};
    vt[6]  = '{8'h72, 0, 1, 8'h72, 0, 1, 0};
    vt[7]  = '{8'h1C, 1, 1, 8'h72, 0, 0, 1};
    vt[8]  = '{8'h1C, 0, 0, 8'h72, 0, 0, 1};
    vt[9]  = '{8'hE0, 0, 1, 8'h72, 0, 0, 0};
    vt[10] = '{8'h1C, 1, 1, 8'h72, 0, 0, 1};
    vt[11] = '{8'h2A, 0, 1, 8'h2A, 0, 1, 0};
    vt[12] = '{8'hF0, 0, 1, 8'h2A, 0, 0, 0};
    vt[13] = '{8'h3C, 0, 0, 8'h2A, 0, 0, 1};
    vt[14] = '{8'h1B, 0, 1, 8'h1B, 0, 1, 0};

    #2;
    chk_outs_reset("rst_async");
    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(FL + 4);
    chk_outs_reset("rst_idle");

    for (int i = 0; i < 15; i++) begin
      s0 = n_strobe;
      e0 = n_ferr;
      send_frame(vt[i].b, vt[i].pflip, vt[i].stopb);
      chk($sformatf("v%0d_key", i), int'(keycode), int'(vt[i].key));
      chk($sformatf("v%0d_ext", i), int'(ext_o), int'(vt[i].ext));
      chk($sformatf("v%0d_stb", i), n_strobe - s0, vt[i].ns);
      chk($sformatf("v%0d_ferr", i), n_ferr - e0, vt[i].ne);
      if (vt[i].ns + vt[i].ne == 1) begin
        chk($sformatf("v%0d_lat", i), last_ev - fall_cyc, 2 + FL + 1);
      end
    end

    s0 = n_strobe;
    e0 = n_ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cyc(TO + 60);
    chk("to_stb", n_strobe - s0, 0);
    chk("to_ferr", n_ferr - e0, 0);
    chk("to_key", int'(keycode), 8'h1B);
    send_frame(8'h23, 0, 1);
    chk("to_next_key", int'(keycode), 8'h23);
    chk("to_next_stb", n_strobe - s0, 1);
    chk("to_next_ferr", n_ferr - e0, 0);

    s0   = n_strobe;
    e0   = n_ferr;
    data = 1'b0;
    wait_cyc(HALF);
    ps2clk = 1'b0;
    wait_cyc(FL - 2);
    ps2clk = 1'b1;
    wait_cyc(HALF);
    data = 1'b1;
    wait_cyc(HALF);
    chk("gl_stb", n_strobe - s0, 0);
    chk("gl_ferr", n_ferr - e0, 0);
    send_frame(8'h1B, 0, 1);
    chk("gl_next_key", int'(keycode), 8'h1B);
    chk("gl_next_stb", n_strobe - s0, 1);

    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk_outs_reset("rst_mid");
    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(FL + 4);
    chk_outs_reset("rst_after");
    s0 = n_strobe;
    e0 = n_ferr;
    send_frame(8'h1D, 0, 1);
    chk("rst_next_key", int'(keycode), 8'h1D);
    chk("rst_next_ext", int'(ext_o), 0);
    chk("rst_next_stb", n_strobe - s0, 1);
    chk("rst_next_ferr", n_ferr - e0, 0);
    chk("rst_next_lat", last_ev - fall_cyc, 2 + FL + 1);

    chk("no_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
